// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller driving one external combinational full adder, LSB first.
// Optional signed-overflow flag output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_cy,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled on a rising edge only in IDLE or DONE; done is a
  // one-cycle pulse and sum/cout stay valid until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_fa_a;
  logic             w_fa_b;
  logic             w_fa_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the adder only sees operand bits while an add is running
  always_comb begin
    w_fa_a = 1'b0;
    w_fa_b = 1'b0;
    w_fa_c = 1'b0;
    if (r_state == S_RUN) begin
      w_fa_a = r_a_sh[0];
      w_fa_b = r_b_sh[0];
      w_fa_c = r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_sum_sh <= {fa_s, r_sum_sh[WIDTH-1:1]};
        r_a_sh   <= r_a_sh >> 1;
        r_b_sh   <= r_b_sh >> 1;
        r_carry  <= fa_cy;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          // Include the MSB sum bit produced on this same edge
          r_sum  <= {fa_s, r_sum_sh[WIDTH-1:1]};
          r_cout <= fa_cy;
        end
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // Carry into the MSB differs from carry out of the MSB on signed overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_carry ^ fa_cy;
  end

  assign ovf = r_ovf;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign fa_a      = w_fa_a;
  assign fa_b      = w_fa_b;
  assign fa_c      = w_fa_c;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl with a behavioural full adder on the fa_* ports.
// Build with SERIAL_ADD_OVF_EN defined to also check the overflow flag.
module tb_serial_add_ctrl;

  localparam int W     = 8;
  localparam int EXP_W = W + 2;  // {ovf, cout, sum}

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_c;
  logic         fa_s;
  logic         fa_cy;
  logic [1:0]   dbg_state;
  logic         ovf_obs;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;

  logic [EXP_W-1:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_c     (fa_c),
    .fa_s     (fa_s),
    .fa_cy    (fa_cy),
`ifdef SERIAL_ADD_OVF_EN
    .ovf      (ovf_obs),
`endif
    .dbg_state(dbg_state)
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_cy = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifndef SERIAL_ADD_OVF_EN
    v = 1'b0;
`endif
    return {v, s};
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        check("result", 32'({ovf_obs, cout, sum}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver: present operands with start for one accepting edge, then scramble inputs
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    exp_q.push_back(model(av, bv, cv));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Count negedges until done is seen, bounded
  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) cyc++;
      @(negedge clk);
    end
  endtask

  int cyc;
  bit ok;
  int d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    check("rst_ovf", 32'(ovf_obs), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);

    // Basic add with latency check
    drive_start(8'h5A, 8'h3C, 1'b0);
    wait_done(20, cyc, ok);
    check("t1_done_seen", 32'(ok), 32'd1);
    check("t1_busy_cycles", 32'(cyc), 32'd8);
    check("t1_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_sum_held", 32'(sum), 32'h96);

    drive_start(8'hFF, 8'h01, 1'b0);
    wait_done(20, cyc, ok);
    check("t2_done_seen", 32'(ok), 32'd1);
    @(negedge clk);

    drive_start(8'h80, 8'h80, 1'b1);
    wait_done(20, cyc, ok);
    check("t3_done_seen", 32'(ok), 32'd1);
    @(negedge clk);

    // Starts during RUN are ignored
    d0 = n_done;
    drive_start(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_sum_stable_in_run", 32'(sum), 32'h01);
    wait_done(20, cyc, ok);
    check("t4_done_seen", 32'(ok), 32'd1);
    repeat (12) @(negedge clk);
    check("t4_single_done", 32'(n_done - d0), 32'd1);
    check("t4_sum", 32'(sum), 32'h46);

    // Reset in the middle of RUN
    drive_start(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum", 32'(sum), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    check("t5_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    exp_q.delete();
    d0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    drive_start(8'h01, 8'h01, 1'b0);
    wait_done(20, cyc, ok);
    check("t5_done_seen", 32'(ok), 32'd1);
    @(negedge clk);
    check("t5_sum_after", 32'(sum), 32'h02);

    // Start held high: back-to-back operations
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    wait_done(20, cyc, ok);
    check("t6_done1_seen", 32'(ok), 32'd1);
    a = 8'h0F; b = 8'h01; cin = 1'b0;
    exp_q.push_back(model(8'h0F, 8'h01, 1'b0));
    @(negedge clk);
    check("t6_busy_reassert", 32'(busy), 32'd1);
    check("t6_done_low", 32'(done), 32'd0);
    check("t6_sum_held", 32'(sum), 32'h30);
    wait_done(20, cyc, ok);
    check("t6_done2_seen", 32'(ok), 32'd1);
    check("t6_period", 32'(cyc + 1), 32'd9);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_sum", 32'(sum), 32'h10);
    check("t6_idle", 32'(dbg_state), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
